// File: rtl/alu_flags.sv
// Flags register downstream of the ALU: captures or loads the five flags,
// evaluates branch conditions, and keeps a small LIFO of saved flag words.
module alu_flags #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_zero,
  input  logic             flag_acarry,
  input  logic             flag_lcarry,
  input  logic             flag_sign,
  input  logic             flag_overflow,
  input  logic             capture,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             load,
  input  logic             assert_bus,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_en,
  input  logic             push,
  input  logic             pop,
  input  logic [3:0]       cond,
  output logic             cond_true,
  output logic [4:0]       flags,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]    flags_q, flags_d, live;
  logic [CW-1:0] count, top;
  logic [4:0]    stk [DEPTH];
  logic          do_push, do_pop, misuse;
  logic          unused_bits;

  assign live        = {flag_overflow, flag_sign, flag_lcarry, flag_acarry, flag_zero};
  assign unused_bits = ^bus_in[WIDTH-1:5];

  assign stack_empty = (count == '0);
  assign stack_full  = (count == CW'(DEPTH));
  assign top         = count - CW'(1);

  // Simultaneous push and pop is treated as misuse: neither touches the stack.
  assign do_push = push & ~pop & ~stack_full;
  assign do_pop  = pop & ~push & ~stack_empty;
  assign misuse  = (push & pop) | (push & stack_full) | (pop & stack_empty);

  always_comb begin
    flags_d = flags_q;
    if (do_pop)       flags_d = stk[top[AW-1:0]];
    else if (load)    flags_d = bus_in[4:0];
    else if (capture) flags_d = live;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= '0;
      count     <= '0;
      stack_err <= 1'b0;
    end else begin
      flags_q <= flags_d;
      if (do_push)     count <= count + CW'(1);
      else if (do_pop) count <= top;
      if (misuse) stack_err <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; only count qualifies its contents.
  always_ff @(posedge clk) begin
    if (do_push) stk[count[AW-1:0]] <= flags_q;
  end

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      4'd0:  cond_true = 1'b1;
      4'd1:  cond_true = flags_q[0];
      4'd2:  cond_true = ~flags_q[0];
      4'd3:  cond_true = flags_q[1];
      4'd4:  cond_true = ~flags_q[1];
      4'd5:  cond_true = flags_q[2];
      4'd6:  cond_true = ~flags_q[2];
      4'd7:  cond_true = flags_q[3];
      4'd8:  cond_true = ~flags_q[3];
      4'd9:  cond_true = flags_q[4];
      4'd10: cond_true = ~flags_q[4];
      4'd11: cond_true = flags_q[3] ^ flags_q[4];
      4'd12: cond_true = ~(flags_q[3] ^ flags_q[4]);
      4'd13: cond_true = flags_q[1] & ~flags_q[0];
      4'd14: cond_true = ~flags_q[1] | flags_q[0];
      4'd15: cond_true = ~flags_q[0] & ~(flags_q[3] ^ flags_q[4]);
      default: cond_true = 1'b1;
    endcase
  end

  assign flags   = flags_q;
  assign bus_out = {{(WIDTH-5){1'b0}}, flags_q};
  assign bus_en  = ~assert_bus;
endmodule
